// File: rtl/dmem_pipe.sv
// Pipelined data memory for an RV32 load/store unit.
// Optional fault detection is compiled in by DMEM_PIPE_ERR_CHECK_EN.
module dmem_pipe #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  size_e         sz;
  logic          uns;
  logic          err;
  logic          acc;
  logic          stall;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          wr_en;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        rd_q [LATENCY];
  logic [31:0]        rd_d [LATENCY];

  assign idx       = req_addr[AW+1:2];
  assign boff      = req_addr[1:0];
  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = ~stall;
  assign acc       = req_valid & req_ready & ~rst;

  // Illegal codes fall back to word size.
  always_comb begin
    sz  = SZ_W;
    uns = req_funct3[2];
    if (req_we) begin
      case (req_funct3)
        3'b000:  sz = SZ_B;
        3'b001:  sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (req_funct3)
        3'b000,
        3'b100:  sz = SZ_B;
        3'b001,
        3'b101:  sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
  end

`ifdef DMEM_PIPE_ERR_CHECK_EN
  logic ill;
  logic mis;
  logic oor;

  always_comb begin
    if (req_we) ill = req_funct3 > 3'b010;
    else        ill = (req_funct3 == 3'b011) ||
                      (req_funct3[2:1] == 2'b11);
    mis = ((sz == SZ_H) && boff[0]) ||
          ((sz == SZ_W) && (boff != 2'b00));
    oor = |req_addr[31:AW+2];
    err = ill | mis | oor;
  end
`else
  logic unused_addr;

  assign err         = 1'b0;
  assign unused_addr = ^req_addr[31:AW+2];
`endif

  always_comb begin
    word    = mem_q[idx];
    byte_v  = 8'(word >> {boff, 3'b000});
    half_v  = boff[1] ? word[31:16] : word[15:0];
    ld_data = word;
    case (sz)
      SZ_B: ld_data = uns ? {24'b0, byte_v}
                          : {{24{byte_v[7]}}, byte_v};
      SZ_H: ld_data = uns ? {16'b0, half_v}
                          : {{16{half_v[15]}}, half_v};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = req_wdata;
    case (sz)
      SZ_B: begin
        wr_be   = 4'b0001 << boff;
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        wr_be   = boff[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
    wr_en = acc & req_we & ~err;
  end

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    rd_d  = rd_q;
    if (!stall) begin
      vld_d[0] = acc;
      err_d[0] = acc & err;
      rd_d[0]  = (acc && !req_we && !err) ? ld_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        rd_d[i]  = rd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) rd_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_rdata = rd_q[LATENCY-1];
  assign rsp_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: three instances with LATENCY 1, 2 and 3.
// Error expectations follow DMEM_PIPE_ERR_CHECK_EN.
module tb_dmem_pipe;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [2:0]  req_funct3[3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t tbl[$];
  vec_t bq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_pipe #(
      .DEPTH  (1024),
      .LATENCY(g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic er,
                              input string nm);
    vec_t v;
    v.we = we;
    v.f3 = f3;
    v.a  = a;
    v.wd = wd;
    v.rd = rd;
    v.er = er;
    v.nm = nm;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input vec_t v);
    req_valid[d]  = 1'b1;
    req_we[d]     = v.we;
    req_funct3[d] = v.f3;
    req_addr[d]   = v.a;
    req_wdata[d]  = v.wd;
  endtask

  // One isolated request; response expected exactly d+1 edges later.
  task automatic single(input int d, input vec_t v);
    rsp_ready[d] = 1'b1;
    drive(d, v);
    #1;
    chk({v.nm, "_rdy"}, 32'(req_ready[d]), 32'd1);
    chk({v.nm, "_idle"}, 32'(rsp_valid[d]), 32'd0);
    cyc();
    req_valid[d] = 1'b0;
    for (int i = 0; i < d; i++) begin
      chk({v.nm, "_early"}, 32'(rsp_valid[d]), 32'd0);
      cyc();
    end
    chk({v.nm, "_v"}, 32'(rsp_valid[d]), 32'd1);
    chk({v.nm, "_rd"}, rsp_rdata[d], v.rd);
    chk({v.nm, "_err"}, 32'(rsp_err[d]), 32'(v.er));
    cyc();
  endtask

  // Streams bq back to back; rsp_ready is low in cycles s0..s1.
  task automatic run_burst(input int d, input int s0, input int s1,
                           input string nm);
    int          k = 0;
    int          r = 0;
    int          c = 0;
    logic        pst = 1'b0;
    logic        pv = 1'b0;
    logic        pe = 1'b0;
    logic [31:0] prd = '0;
    int          seen = 0;
    while (r < bq.size() && c < 60) begin
      rsp_ready[d] = !(c >= s0 && c <= s1);
      if (k < bq.size()) drive(d, bq[k]);
      else req_valid[d] = 1'b0;
      #1;
      if (pst) begin
        chk({nm, "_hold_v"}, 32'(rsp_valid[d]), 32'(pv));
        chk({nm, "_hold_rd"}, rsp_rdata[d], prd);
        chk({nm, "_hold_e"}, 32'(rsp_err[d]), 32'(pe));
      end
      pst = rsp_valid[d] && !rsp_ready[d];
      if (pst) begin
        chk({nm, "_rdy_stall"}, 32'(req_ready[d]), 32'd0);
        seen++;
      end
      pv  = rsp_valid[d];
      prd = rsp_rdata[d];
      pe  = rsp_err[d];
      if (rsp_valid[d] && rsp_ready[d]) begin
        chk({nm, "_", bq[r].nm}, rsp_rdata[d], bq[r].rd);
        chk({nm, "_err"}, 32'(rsp_err[d]), 32'(bq[r].er));
        r++;
      end
      if (req_valid[d] && req_ready[d]) k++;
      cyc();
      c++;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    chk({nm, "_count"}, 32'(r), 32'(bq.size()));
    if (s0 <= s1) chk({nm, "_stalled"}, 32'(seen > 0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_no_dup"}, 32'(rsp_valid[d]), 32'd0);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = F_W;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      rsp_ready[d]  = 1'b1;
    end
    repeat (2) cyc();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
    end

    tbl.push_back(mk(1, F_W,  32'h10, 32'hDEADBEEF, 0, 0, "sw10"));
    tbl.push_back(mk(0, F_W,  32'h10, 0, 32'hDEADBEEF, 0, "lw10"));
    tbl.push_back(mk(1, F_W,  32'h10, 32'h11223344, 0, 0, "sw10b"));
    tbl.push_back(mk(1, F_B,  32'h13, 32'hAAAAAA80, 0, 0, "sb13"));
    tbl.push_back(mk(0, F_B,  32'h13, 0, 32'hFFFFFF80, 0, "lb13"));
    tbl.push_back(mk(0, F_BU, 32'h13, 0, 32'h00000080, 0, "lbu13"));
    tbl.push_back(mk(0, F_W,  32'h10, 0, 32'h80223344, 0, "lw10b"));
    tbl.push_back(mk(1, F_W,  32'h20, 32'h55667788, 0, 0, "sw20"));
    tbl.push_back(mk(1, F_H,  32'h22, 32'hFFFF8001, 0, 0, "sh22"));
    tbl.push_back(mk(0, F_W,  32'h20, 0, 32'h80017788, 0, "lw20"));
    tbl.push_back(mk(0, F_H,  32'h22, 0, 32'hFFFF8001, 0, "lh22"));
    tbl.push_back(mk(0, F_HU, 32'h22, 0, 32'h00008001, 0, "lhu22"));
    tbl.push_back(mk(0, F_H,  32'h20, 0, 32'h00007788, 0, "lh20"));
    tbl.push_back(mk(0, F_B,  32'h21, 0, 32'h00000077, 0, "lb21"));
    tbl.push_back(mk(0, F_BU, 32'h20, 0, 32'h00000088, 0, "lbu20"));
    tbl.push_back(mk(1, F_B,  32'h20, 32'h000000F1, 0, 0, "sb20"));
    tbl.push_back(mk(0, F_B,  32'h20, 0, 32'hFFFFFFF1, 0, "lb20"));
    tbl.push_back(mk(0, F_W,  32'h20, 0, 32'h800177F1, 0, "lw20b"));
    tbl.push_back(mk(0, F_HU, 32'h20, 0, 32'h000077F1, 0, "lhu20"));
    for (int i = 0; i < tbl.size(); i++) single(0, tbl[i]);

`ifdef DMEM_PIPE_ERR_CHECK_EN
    single(0, mk(1, F_W, 32'h12, 32'h99999999, 0, 1, "sw_mis"));
    single(0, mk(0, F_W, 32'h10, 0, 32'h80223344, 0, "lw_keep"));
    single(0, mk(0, F_H, 32'h1001, 0, 0, 1, "lh_oor"));
    single(0, mk(0, 3'b011, 32'h10, 0, 0, 1, "ld_ill"));
    single(0, mk(1, 3'b100, 32'h10, 32'h12345678, 0, 1, "st_ill"));
    single(0, mk(0, F_W, 32'h1010, 0, 0, 1, "lw_oor"));
    single(0, mk(0, F_W, 32'h10, 0, 32'h80223344, 0, "lw_keep2"));
`else
    single(0, mk(1, F_W, 32'h4, 32'h0BADF00D, 0, 0, "sw4"));
    single(0, mk(0, F_W, 32'h1004, 0, 32'h0BADF00D, 0, "lw_wrap"));
    single(0, mk(0, F_W, 32'h12, 0, 32'h80223344, 0, "lw_mis"));
    single(0, mk(0, 3'b011, 32'h10, 0, 32'h80223344, 0, "ld_ill"));
    single(0, mk(0, F_H, 32'h23, 0, 32'hFFFF8001, 0, "lh_mis"));
    single(0, mk(1, 3'b100, 32'h14, 32'h12345678, 0, 0, "st_ill"));
    single(0, mk(0, F_W, 32'h14, 0, 32'h12345678, 0, "lw_st_ill"));
`endif

    bq.delete();
    bq.push_back(mk(1, F_W,  32'h40, 32'hA5A5A5A5, 0, 0, "sw40"));
    bq.push_back(mk(0, F_W,  32'h40, 0, 32'hA5A5A5A5, 0, "lw40"));
    bq.push_back(mk(1, F_B,  32'h41, 32'h0000003C, 0, 0, "sb41"));
    bq.push_back(mk(0, F_W,  32'h40, 0, 32'hA5A53CA5, 0, "lw40b"));
    bq.push_back(mk(0, F_BU, 32'h41, 0, 32'h0000003C, 0, "lbu41"));
    run_burst(0, 1, 0, "b2b");

    bq.delete();
    for (int i = 0; i < 5; i++)
      bq.push_back(mk(1, F_W, 32'(32'h100 + 4*i),
                      32'(32'h10000000 + i), 0, 0, "st"));
    run_burst(2, 1, 0, "l3st");
    bq.delete();
    for (int i = 0; i < 5; i++)
      bq.push_back(mk(0, F_W, 32'(32'h100 + 4*i), 0,
                      32'(32'h10000000 + i), 0, $sformatf("ld%0d", i)));
    run_burst(2, 4, 6, "l3stall");

    single(1, mk(1, F_W, 32'h8, 32'hCAFEF00D, 0, 0, "sw8"));
    rsp_ready[1] = 1'b0;
    drive(1, mk(0, F_W, 32'h8, 0, 0, 0, "ldA"));
    #1;
    chk("rst_accA", 32'(req_ready[1]), 32'd1);
    cyc();
    #1;
    chk("rst_accB", 32'(req_ready[1]), 32'd1);
    cyc();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_ready[1] = 1'b1;
    chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("mid_rst_rdata", rsp_rdata[1], 32'd0);
    chk("mid_rst_err", 32'(rsp_err[1]), 32'd0);
    chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_drop", 32'(rsp_valid[1]), 32'd0);
      cyc();
    end

    drive(1, mk(1, F_W, 32'h8, 32'h77777777, 0, 0, "sw_rst"));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_acc", 32'(rsp_valid[1]), 32'd0);
      cyc();
    end
    single(1, mk(0, F_W, 32'h8, 0, 32'hCAFEF00D, 0, "lw8_keep"));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
